// File: rtl/hilo_result_responder_pkg.sv
// rtl/hilo_result_responder_pkg.sv - shared state encoding and register selectors for the HI/LO responder
package hilo_result_responder_pkg;

   typedef enum logic [1:0] {
      HILO_IDLE = 2'd0,
      HILO_BUSY = 2'd1,
      HILO_HELD = 2'd2
   } hilo_state;

   localparam logic HILO_SEL_LO = 1'b0;
   localparam logic HILO_SEL_HI = 1'b1;

   localparam int HILO_TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/hilo_result_responder_if.sv
// rtl/hilo_result_responder_if.sv - pipeline/unit-facing signal bundle of the HI/LO responder
interface hilo_result_responder_if #(
   parameter int WIDTH = 32
) ();

   logic             issue;
   logic             cancel;
   logic             wb_stall;
   logic             res_valid;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic             hold_result;
   logic             clear;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             mf_req;
   logic             mf_sel;
   logic             mf_valid;
   logic [WIDTH-1:0] mf_data;
   logic             mt_we;
   logic             mt_sel;
   logic [WIDTH-1:0] mt_data;
   logic             stall;
   logic             busy;

   modport slave (
      input  issue, cancel, wb_stall, res_valid, res_hi, res_lo,
      input  mf_req, mf_sel, mt_we, mt_sel, mt_data,
      output hold_result, clear, hi_q, lo_q, mf_valid, mf_data, stall, busy
   );

   modport master (
      output issue, cancel, wb_stall, res_valid, res_hi, res_lo,
      output mf_req, mf_sel, mt_we, mt_sel, mt_data,
      input  hold_result, clear, hi_q, lo_q, mf_valid, mf_data, stall, busy
   );

endinterface

// File: rtl/hilo_regfile.sv
// rtl/hilo_regfile.sv - architectural HI/LO registers with move-to write, move-from read and commit port
module hilo_regfile
   import hilo_result_responder_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             commit,
   input  logic [WIDTH-1:0] commit_hi,
   input  logic [WIDTH-1:0] commit_lo,
   input  logic             wr_en,
   input  logic             wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic             rd_sel,
   output logic [WIDTH-1:0] hi_q,
   output logic [WIDTH-1:0] lo_q,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data
);

   // Read samples the registers before any same-cycle write lands, so a move-from
   // paired with a move-to returns the old value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hi_q     <= '0;
         lo_q     <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= (rd_sel == HILO_SEL_HI) ? hi_q : lo_q;
         end
         if (commit) begin
            hi_q <= commit_hi;
            lo_q <= commit_lo;
         end else if (wr_en) begin
            if (wr_sel == HILO_SEL_LO) begin
               lo_q <= wr_data;
            end else begin
               hi_q <= wr_data;
            end
         end
      end
   end

endmodule

// File: rtl/hilo_result_responder.sv
// rtl/hilo_result_responder.sv - HI/LO owner tracking mul/div ops to commit; HILO_TIMEOUT_EN adds a BUSY watchdog
module hilo_result_responder
   import hilo_result_responder_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   hilo_result_responder_if.slave  bus
`ifdef HILO_TIMEOUT_EN
   ,
   output logic                    timeout_err
`endif
);

   hilo_state        state_q;
   hilo_state        state_d;
   logic             idle;
   logic             accept_issue;
   logic             timeout_hit;
   logic             commit;
   logic             capture;
   logic             hold;
   logic             clear;
   logic [WIDTH-1:0] held_hi;
   logic [WIDTH-1:0] held_lo;
   logic [WIDTH-1:0] commit_hi;
   logic [WIDTH-1:0] commit_lo;

   assign idle         = (state_q == HILO_IDLE);
   assign accept_issue = idle & bus.issue & ~bus.cancel;

`ifdef HILO_TIMEOUT_EN
   logic [HILO_TIMEOUT_CNT_W-1:0] to_cnt;

   assign timeout_hit = (state_q == HILO_BUSY) & ~bus.res_valid &
                        (to_cnt == HILO_TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (accept_issue) begin
            to_cnt <= '0;
         end else if (state_q == HILO_BUSY) begin
            to_cnt <= to_cnt + 1'b1;
         end
         if (timeout_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end
`else
   logic unused_timeout_cfg;

   assign timeout_hit        = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= HILO_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         HILO_IDLE: begin
            if (bus.issue && !bus.cancel) state_d = HILO_BUSY;
         end
         HILO_BUSY: begin
            if (bus.cancel || timeout_hit) state_d = HILO_IDLE;
            else if (bus.res_valid)        state_d = bus.wb_stall ? HILO_HELD : HILO_IDLE;
         end
         HILO_HELD: begin
            if (bus.cancel || !bus.wb_stall) state_d = HILO_IDLE;
         end
         default: state_d = HILO_IDLE;
      endcase
   end

   // Cancel outranks both a fresh result and a released held result.
   always_comb begin
      commit  = 1'b0;
      capture = 1'b0;
      hold    = 1'b0;
      clear   = 1'b0;
      case (state_q)
         HILO_BUSY: begin
            if (bus.cancel || timeout_hit) begin
               clear = 1'b1;
            end else if (bus.res_valid) begin
               if (bus.wb_stall) begin
                  hold    = 1'b1;
                  capture = 1'b1;
               end else begin
                  commit = 1'b1;
               end
            end
         end
         HILO_HELD: begin
            hold = 1'b1;
            if (bus.cancel)         clear  = 1'b1;
            else if (!bus.wb_stall) commit = 1'b1;
         end
         default: ;
      endcase
   end

   // Own copy of the stalled result so the unit is free to move on.
   always_ff @(posedge clk) begin
      if (!reset) begin
         held_hi <= '0;
         held_lo <= '0;
      end else if (capture) begin
         held_hi <= bus.res_hi;
         held_lo <= bus.res_lo;
      end
   end

   assign commit_hi = (state_q == HILO_HELD) ? held_hi : bus.res_hi;
   assign commit_lo = (state_q == HILO_HELD) ? held_lo : bus.res_lo;

   assign bus.hold_result = hold & reset;
   assign bus.clear       = clear & reset;
   assign bus.stall       = ~idle & (bus.issue | bus.mf_req | bus.mt_we) & reset;
   assign bus.busy        = ~idle;

   hilo_regfile #(
      .WIDTH (WIDTH)
   ) u_regfile (
      .clk       (clk),
      .reset     (reset),
      .commit    (commit),
      .commit_hi (commit_hi),
      .commit_lo (commit_lo),
      .wr_en     (idle & bus.mt_we),
      .wr_sel    (bus.mt_sel),
      .wr_data   (bus.mt_data),
      .rd_en     (idle & bus.mf_req),
      .rd_sel    (bus.mf_sel),
      .hi_q      (bus.hi_q),
      .lo_q      (bus.lo_q),
      .rd_valid  (bus.mf_valid),
      .rd_data   (bus.mf_data)
   );

endmodule

// File: tb/tb_hilo_result_responder.sv
// tb/tb_hilo_result_responder.sv - directed self-checking bench with move-from scoreboard
module tb_hilo_result_responder;

   logic        clk = 1'b0;
   logic        reset;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] mf_exp_q[$];
   logic [31:0] sb_exp;

   always #5 clk = ~clk;

   hilo_result_responder_if #(.WIDTH(32)) bus ();

`ifdef HILO_TIMEOUT_EN
   logic timeout_err;
`endif

   hilo_result_responder #(
      .WIDTH          (32),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef HILO_TIMEOUT_EN
      ,
      .timeout_err (timeout_err)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   always @(negedge clk) begin
      if (bus.mf_valid === 1'b1) begin
         if (mf_exp_q.size() == 0) begin
            chk1("mf_unexpected", bus.mf_valid, 1'b0);
         end else begin
            sb_exp = mf_exp_q.pop_front();
            chk("mf_data_sb", bus.mf_data, sb_exp);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b0;
      bus.issue     = 1'b0;
      bus.cancel    = 1'b0;
      bus.wb_stall  = 1'b0;
      bus.res_valid = 1'b0;
      bus.res_hi    = '0;
      bus.res_lo    = '0;
      bus.mf_req    = 1'b0;
      bus.mf_sel    = 1'b0;
      bus.mt_we     = 1'b0;
      bus.mt_sel    = 1'b0;
      bus.mt_data   = '0;
      tick();
      tick();
      settle();
      chk("rst_hi", bus.hi_q, 32'h0);
      chk("rst_lo", bus.lo_q, 32'h0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_stall", bus.stall, 1'b0);
      chk1("rst_hold", bus.hold_result, 1'b0);
      chk1("rst_clear", bus.clear, 1'b0);
      chk1("rst_mf_valid", bus.mf_valid, 1'b0);
      chk("rst_mf_data", bus.mf_data, 32'h0);
      reset = 1'b1;

      // basic commit, BUSY for exactly 5 cycles
      bus.issue = 1'b1;
      settle();
      chk1("issue_no_stall", bus.stall, 1'b0);
      tick();
      bus.issue = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk1("busy_window", bus.busy, 1'b1);
         if (i == 4) begin
            bus.res_valid = 1'b1;
            bus.res_hi    = 32'h0000_0001;
            bus.res_lo    = 32'hFFFF_FFFE;
         end
         tick();
      end
      bus.res_valid = 1'b0;
      settle();
      chk1("busy_after_commit", bus.busy, 1'b0);
      chk("commit_hi", bus.hi_q, 32'h0000_0001);
      chk("commit_lo", bus.lo_q, 32'hFFFF_FFFE);

      // move-from stalled while BUSY, accepted after commit
      bus.issue = 1'b1;
      tick();
      bus.issue  = 1'b0;
      bus.mf_req = 1'b1;
      bus.mf_sel = 1'b1;
      settle();
      chk1("mf_busy_stall", bus.stall, 1'b1);
      tick();
      settle();
      chk1("mf_busy_stall2", bus.stall, 1'b1);
      chk1("mf_stalled_no_valid", bus.mf_valid, 1'b0);
      bus.res_valid = 1'b1;
      bus.res_hi    = 32'h1234_5678;
      bus.res_lo    = 32'h9ABC_DEF0;
      settle();
      chk1("commit_cycle_stall", bus.stall, 1'b1);
      tick();
      bus.res_valid = 1'b0;
      settle();
      chk1("post_commit_no_stall", bus.stall, 1'b0);
      chk("mf_new_hi", bus.hi_q, 32'h1234_5678);
      mf_exp_q.push_back(32'h1234_5678);
      tick();
      bus.mf_req = 1'b0;
      settle();
      chk1("mf_valid_lat1", bus.mf_valid, 1'b1);
      chk("mf_data_hi", bus.mf_data, 32'h1234_5678);
      tick();
      chk1("mf_valid_drop", bus.mf_valid, 1'b0);

      // writeback-stalled commit uses the value captured at the first strobe
      bus.issue = 1'b1;
      tick();
      bus.issue     = 1'b0;
      bus.res_valid = 1'b1;
      bus.wb_stall  = 1'b1;
      bus.res_hi    = 32'hAAAA_0001;
      bus.res_lo    = 32'h5555_0002;
      settle();
      chk1("hold_entry", bus.hold_result, 1'b1);
      tick();
      bus.res_valid = 1'b0;
      bus.res_hi    = 32'hDEAD_0000;
      bus.res_lo    = 32'h0BAD_0000;
      settle();
      chk1("hold_held1", bus.hold_result, 1'b1);
      chk1("held_busy", bus.busy, 1'b1);
      tick();
      settle();
      chk1("hold_held2", bus.hold_result, 1'b1);
      bus.wb_stall = 1'b0;
      tick();
      settle();
      chk("held_commit_hi", bus.hi_q, 32'hAAAA_0001);
      chk("held_commit_lo", bus.lo_q, 32'h5555_0002);
      chk1("hold_released", bus.hold_result, 1'b0);
      chk1("held_done_idle", bus.busy, 1'b0);

      // cancel in BUSY
      bus.issue = 1'b1;
      tick();
      bus.issue  = 1'b0;
      bus.cancel = 1'b1;
      settle();
      chk1("cancel_busy_clear", bus.clear, 1'b1);
      tick();
      bus.cancel = 1'b0;
      settle();
      chk1("cancel_busy_clear_drop", bus.clear, 1'b0);
      chk1("cancel_busy_idle", bus.busy, 1'b0);
      chk("cancel_busy_hi", bus.hi_q, 32'hAAAA_0001);

      // cancel in HELD together with wb_stall release: cancel wins
      bus.issue = 1'b1;
      tick();
      bus.issue     = 1'b0;
      bus.res_valid = 1'b1;
      bus.wb_stall  = 1'b1;
      bus.res_hi    = 32'h0000_0111;
      bus.res_lo    = 32'h0000_0222;
      tick();
      bus.res_valid = 1'b0;
      bus.wb_stall  = 1'b0;
      bus.cancel    = 1'b1;
      settle();
      chk1("cancel_held_clear", bus.clear, 1'b1);
      tick();
      bus.cancel = 1'b0;
      settle();
      chk1("cancel_held_clear_drop", bus.clear, 1'b0);
      chk1("cancel_held_idle", bus.busy, 1'b0);
      chk("cancel_held_hi", bus.hi_q, 32'hAAAA_0001);
      chk("cancel_held_lo", bus.lo_q, 32'h5555_0002);

      // next issue accepted after cancel
      bus.issue = 1'b1;
      tick();
      bus.issue = 1'b0;
      chk1("reissue_busy", bus.busy, 1'b1);
      bus.res_valid = 1'b1;
      bus.res_hi    = 32'h0000_000F;
      bus.res_lo    = 32'h0000_00F0;
      tick();
      bus.res_valid = 1'b0;
      settle();
      chk("reissue_hi", bus.hi_q, 32'h0000_000F);
      chk("reissue_lo", bus.lo_q, 32'h0000_00F0);

      // spurious strobe while IDLE
      bus.res_valid = 1'b1;
      bus.res_hi    = 32'hFFFF_FFFF;
      bus.res_lo    = 32'hFFFF_FFFF;
      tick();
      bus.res_valid = 1'b0;
      chk1("spurious_idle", bus.busy, 1'b0);
      chk("spurious_hi", bus.hi_q, 32'h0000_000F);
      chk("spurious_lo", bus.lo_q, 32'h0000_00F0);

      // move-to / move-from ordering
      bus.mt_we   = 1'b1;
      bus.mt_sel  = 1'b0;
      bus.mt_data = 32'hDEAD_BEEF;
      bus.mf_req  = 1'b1;
      bus.mf_sel  = 1'b0;
      mf_exp_q.push_back(32'h0000_00F0);
      tick();
      bus.mt_we = 1'b0;
      mf_exp_q.push_back(32'hDEAD_BEEF);
      settle();
      chk("mf_pre_write", bus.mf_data, 32'h0000_00F0);
      chk("mt_lo", bus.lo_q, 32'hDEAD_BEEF);
      tick();
      bus.mf_req  = 1'b0;
      bus.mt_we   = 1'b1;
      bus.mt_sel  = 1'b1;
      bus.mt_data = 32'h1357_9BDF;
      settle();
      chk("mf_post_write", bus.mf_data, 32'hDEAD_BEEF);
      tick();
      bus.mt_we = 1'b0;
      chk("mt_hi", bus.hi_q, 32'h1357_9BDF);
      chk1("mf_idle_no_valid", bus.mf_valid, 1'b0);
      chk("mf_data_holds", bus.mf_data, 32'hDEAD_BEEF);

      // move-to while BUSY is stalled and dropped
      bus.issue = 1'b1;
      tick();
      bus.issue   = 1'b0;
      bus.mt_we   = 1'b1;
      bus.mt_sel  = 1'b1;
      bus.mt_data = 32'hBADB_AD00;
      settle();
      chk1("mt_busy_stall", bus.stall, 1'b1);
      tick();
      bus.mt_we  = 1'b0;
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      chk("mt_stalled_no_write", bus.hi_q, 32'h1357_9BDF);

      // issue, move-from and move-to in one IDLE cycle
      bus.issue   = 1'b1;
      bus.mf_req  = 1'b1;
      bus.mf_sel  = 1'b1;
      bus.mt_we   = 1'b1;
      bus.mt_sel  = 1'b0;
      bus.mt_data = 32'h0C0F_FEE0;
      mf_exp_q.push_back(32'h1357_9BDF);
      settle();
      chk1("triple_no_stall", bus.stall, 1'b0);
      tick();
      bus.issue  = 1'b0;
      bus.mf_req = 1'b0;
      bus.mt_we  = 1'b0;
      settle();
      chk1("triple_busy", bus.busy, 1'b1);
      chk("triple_lo", bus.lo_q, 32'h0C0F_FEE0);
      chk1("triple_mf_valid", bus.mf_valid, 1'b1);

      // reset while HELD discards the pending result
      bus.res_valid = 1'b1;
      bus.wb_stall  = 1'b1;
      bus.res_hi    = 32'h7777_7777;
      bus.res_lo    = 32'h8888_8888;
      tick();
      bus.res_valid = 1'b0;
      settle();
      chk1("pre_reset_held", bus.hold_result, 1'b1);
      reset = 1'b0;
      tick();
      reset        = 1'b1;
      bus.wb_stall = 1'b0;
      settle();
      chk1("midop_reset_busy", bus.busy, 1'b0);
      chk("midop_reset_hi", bus.hi_q, 32'h0);
      chk("midop_reset_lo", bus.lo_q, 32'h0);
      chk1("midop_reset_hold", bus.hold_result, 1'b0);
      tick();
      chk("no_commit_after_reset", bus.hi_q, 32'h0);

`ifdef HILO_TIMEOUT_EN
      chk1("timeout_err_init", timeout_err, 1'b0);
      bus.issue = 1'b1;
      tick();
      bus.issue = 1'b0;
      repeat (63) tick();
      settle();
      chk1("timeout_clear", bus.clear, 1'b1);
      tick();
      chk1("timeout_idle", bus.busy, 1'b0);
      chk1("timeout_err_set", timeout_err, 1'b1);
      chk("timeout_no_commit", bus.hi_q, 32'h0);
`endif

      chk("sb_drained", mf_exp_q.size(), 32'd0);
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hilo_result_responder.md
Name: hilo_result_responder

Overview:
- Responder end of the multiply/divide request interface. It owns the architectural HI/LO registers and feeds them to the mul/div unit as hi_in/lo_in.
- Tracks each issued op until the unit asserts its result strobe, then commits hi_out/lo_out. While the commit is blocked by a writeback stall, it drives hold_result back to the unit.
- Services MFHI/MFLO/MTHI/MTLO for the pipeline and raises a stall while a result is outstanding.
- Sits beside the execute stage; commit is gated by writeback.

Parameters:
- WIDTH, 32, data width of HI, LO and the result buses.
- TIMEOUT_CYCLES, 64, watchdog limit on BUSY (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- issue  input  1  execute stage launches a mul/div op this cycle.
- cancel  input  1  flush of the issuing or in-flight op.
- wb_stall  input  1  writeback stage cannot accept a HI/LO commit this cycle.
- res_valid  input  1  unit result strobe (write_hi_lo).
- res_hi, res_lo  input  WIDTH  unit result (hi_out/lo_out).
- hold_result  output  1  to unit: keep the presented result stable.
- clear  output  1  to unit: abort the current operation.
- hi_q, lo_q  output  WIDTH  architectural HI/LO, driven to unit hi_in/lo_in.
- mf_req  input  1  move-from request.
- mf_sel  input  1  0 = LO, 1 = HI.
- mf_valid  output  1  read data valid.
- mf_data  output  WIDTH  read data.
- mt_we  input  1  move-to write.
- mt_sel  input  1  0 = LO, 1 = HI.
- mt_data  input  WIDTH  move-to data.
- stall  output  1  pipeline must hold its current request.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (reset low at a clk edge):
  - state = IDLE; hi_q = lo_q = 0.
  - mf_valid = 0, mf_data = 0, hold_result = 0, clear = 0, stall = 0, busy = 0.
  - Reset dominates every other input, including mid-operation (BUSY/HELD). Pending result is discarded; no commit.
- State machine (IDLE, BUSY, HELD):
  - IDLE & issue & !cancel -> BUSY.
  - BUSY & cancel -> IDLE; clear = 1 for exactly that cycle; no commit.
  - BUSY & res_valid & !wb_stall -> commit (hi_q <= res_hi, lo_q <= res_lo at the edge), -> IDLE.
  - BUSY & res_valid & wb_stall -> HELD; hold_result = 1 combinationally in that cycle.
  - HELD: hold_result = 1. Result is captured on entry into internal hold registers; the unit holding it is not relied on.
  - HELD & !wb_stall -> commit the held values, -> IDLE.
  - HELD & cancel -> IDLE, no commit, clear = 1 for one cycle. Cancel beats commit when both occur in the same cycle.
- Stall rule: stall = (state != IDLE) & (issue | mf_req | mt_we). It is combinational and remains asserted through the commit cycle; requests are accepted from the first IDLE cycle after commit. Stalled requests have no effect.
- res_valid in IDLE is ignored (spurious strobe; no HI/LO change).
- Move-from:
  - Accepted mf_req (IDLE, no stall) -> next cycle mf_valid = 1, mf_data = registered selected register. Latency 1.
  - mf_valid is 0 in all other cycles; mf_data holds its last value.
- Move-to:
  - Accepted mt_we writes the selected register at the edge.
  - A move-from in the same cycle returns the pre-write value (no bypass).
- Same-cycle issue with mf_req/mt_we in IDLE: all three are accepted.

Optional Feature:
- Macro HILO_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit-or-wider counter clears on entering BUSY and increments each BUSY cycle.
  - On reaching TIMEOUT_CYCLES without res_valid: clear = 1 for one cycle, state -> IDLE, no commit, and sticky output timeout_err = 1 until reset.
  - HELD is not counted.
- Without the macro: no counter and no timeout_err port; BUSY waits indefinitely.

Decomposition:
- Shared package (in selector): state enum hilo_state {HILO_IDLE, HILO_BUSY, HILO_HELD}; HILO_SEL_LO = 0, HILO_SEL_HI = 1.
- One natural sub-module: hilo_regfile, the two WIDTH registers with select-write, move-from read path and commit port.

Test Plan:
- Basic commit: reset, issue, res_valid after 5 cycles with res_hi=32'h1, res_lo=32'hFFFF_FFFE and wb_stall=0 -> hi_q=1, lo_q=FFFF_FFFE the next cycle; busy high for exactly 5 cycles.
- Writeback-stalled commit: res_valid with wb_stall=1 for 3 cycles, unit changes res_* afterwards -> hold_result=1 for 3 cycles; committed values equal those captured at the first res_valid.
- Move-from during busy: mf_req (sel=HI) while BUSY -> stall=1 until IDLE; mf_valid one cycle after acceptance with the new HI.
- Cancel: cancel in BUSY, then in HELD -> clear pulses for one cycle each time; hi_q/lo_q unchanged; next issue accepted.
- Move-to/move-from ordering: mt_we sel=LO data=32'hDEAD_BEEF together with mf_req sel=LO -> mf_data = old LO; a following mf_req -> DEAD_BEEF.
- Reset mid-op: reset low during HELD -> state IDLE, hi_q = lo_q = 0, hold_result = 0. With HILO_TIMEOUT_EN and TIMEOUT_CYCLES=64: no res_valid for 64 cycles -> clear pulse, timeout_err = 1.
